// File: rtl/dsec_mem_sequencer.sv
// -----------------------------------------------------------------------------
// dsec_mem_sequencer
//
// Moves one block of words through the DSEC core, one word at a time:
// read a word from the source region, hand it to DSEC, wait for the DSEC
// result, then write that result to the destination region.
//
// Optional feature (compile-time macro TIMEOUT_EN):
//   defined   - a counter runs while waiting for DSEC. After TIMEOUT_CYC
//               cycles without dsec_out_valid the transfer is abandoned:
//               error is set and the done pulse still fires.
//   undefined - DSEC is waited on indefinitely and error stays 0.
//
// Ports:
//   clk, rst         clock (rising edge); asynchronous active-low reset
//   start            one-cycle request, accepted only while idle
//   src_base         source start address, captured on accepted start
//   dst_base         destination start address, captured on accepted start
//   len              number of words, captured on accepted start
//   busy             high from the cycle after accepted start through DONE
//   done             one-cycle pulse at the end of a transfer
//   error            DSEC timeout flag, sticky until the next accepted start
//   mem_address      memory word address (held outside request cycles)
//   mem_w_rn         1 = write, 0 = read (held while mem_go is low)
//   mem_go           one-cycle memory access request
//   mem_wdata        memory write data
//   mem_rdata        memory read data, valid with mem_done on a read
//   mem_done         memory access complete
//   dsec_in_valid    one-cycle strobe qualifying dsec_in_data
//   dsec_in_data     word presented to DSEC
//   dsec_out_valid   DSEC result strobe
//   dsec_out_data    DSEC result word
// -----------------------------------------------------------------------------
module dsec_mem_sequencer #(
  parameter int ADDR_W      = 13,
  parameter int DATA_W      = 16,
  parameter int LEN_W       = 13,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_w_rn,
  output logic              mem_go,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_done,
  output logic              dsec_in_valid,
  output logic [DATA_W-1:0] dsec_in_data,
  input  logic              dsec_out_valid,
  input  logic [DATA_W-1:0] dsec_out_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_FEED,
    S_DS_WAIT,
    S_WR_REQ,
    S_WR_WAIT,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  index_q, index_d;
  logic [LEN_W-1:0]  index_inc;

  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic              mem_w_rn_q, mem_w_rn_d;
  logic              mem_go_q, mem_go_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              dsec_in_valid_q, dsec_in_valid_d;
  logic [DATA_W-1:0] dsec_in_data_q, dsec_in_data_d;

`ifdef TIMEOUT_EN
  // Counts completed DS_WAIT cycles; expiry is seen on the TIMEOUT_CYC-th one.
  localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            to_expired;
  assign to_expired = (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
`endif

  assign index_inc = index_q + LEN_W'(1);

  always_comb begin
    state_d         = state_q;
    src_d           = src_q;
    dst_d           = dst_q;
    len_d           = len_q;
    index_d         = index_q;
    error_d         = error_q;
    mem_address_d   = mem_address_q;
    mem_w_rn_d      = mem_w_rn_q;
    mem_wdata_d     = mem_wdata_q;
    dsec_in_data_d  = dsec_in_data_q;
    mem_go_d        = 1'b0;
    dsec_in_valid_d = 1'b0;
    done_d          = 1'b0;
    busy_d          = 1'b0;
`ifdef TIMEOUT_EN
    to_cnt_d        = '0;
`endif

    // Next-state and captured data.
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d   = src_base;
          dst_d   = dst_base;
          len_d   = len;
          index_d = '0;
          error_d = 1'b0;
          state_d = (len == '0) ? S_DONE : S_RD_REQ;
        end
      end
      S_RD_REQ: state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        if (mem_done) begin
          dsec_in_data_d = mem_rdata;
          state_d        = S_FEED;
        end
      end
      S_FEED: state_d = S_DS_WAIT;
      S_DS_WAIT: begin
        if (dsec_out_valid) begin
          mem_wdata_d = dsec_out_data;
          state_d     = S_WR_REQ;
        end
`ifdef TIMEOUT_EN
        // Abandon the rest of the block; no write is issued for this word.
        else if (to_expired) begin
          error_d = 1'b1;
          state_d = S_DONE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
`endif
      end
      S_WR_REQ: state_d = S_WR_WAIT;
      S_WR_WAIT: begin
        if (mem_done) begin
          index_d = index_inc;
          state_d = (index_inc == len_q) ? S_DONE : S_RD_REQ;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    // Address sums use the _d captures because IDLE->RD_REQ captures them now.
    busy_d = (state_d != S_IDLE);
    unique case (state_d)
      S_RD_REQ: begin
        mem_go_d      = 1'b1;
        mem_w_rn_d    = 1'b0;
        mem_address_d = src_d + ADDR_W'(index_d);
      end
      S_WR_REQ: begin
        mem_go_d      = 1'b1;
        mem_w_rn_d    = 1'b1;
        mem_address_d = dst_d + ADDR_W'(index_d);
      end
      S_FEED:  dsec_in_valid_d = 1'b1;
      S_DONE:  done_d          = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= S_IDLE;
      index_q         <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      error_q         <= 1'b0;
      mem_address_q   <= '0;
      mem_w_rn_q      <= 1'b0;
      mem_go_q        <= 1'b0;
      mem_wdata_q     <= '0;
      dsec_in_valid_q <= 1'b0;
      dsec_in_data_q  <= '0;
`ifdef TIMEOUT_EN
      to_cnt_q        <= '0;
`endif
    end else begin
      state_q         <= state_d;
      index_q         <= index_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      error_q         <= error_d;
      mem_address_q   <= mem_address_d;
      mem_w_rn_q      <= mem_w_rn_d;
      mem_go_q        <= mem_go_d;
      mem_wdata_q     <= mem_wdata_d;
      dsec_in_valid_q <= dsec_in_valid_d;
      dsec_in_data_q  <= dsec_in_data_d;
`ifdef TIMEOUT_EN
      to_cnt_q        <= to_cnt_d;
`endif
    end
  end

  // Transfer parameters are only meaningful after a start captures them.
  always_ff @(posedge clk) begin
    src_q <= src_d;
    dst_q <= dst_d;
    len_q <= len_d;
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign mem_address   = mem_address_q;
  assign mem_w_rn      = mem_w_rn_q;
  assign mem_go        = mem_go_q;
  assign mem_wdata     = mem_wdata_q;
  assign dsec_in_valid = dsec_in_valid_q;
  assign dsec_in_data  = dsec_in_data_q;

endmodule

// File: tb/tb_dsec_mem_sequencer.sv
module tb_dsec_mem_sequencer;
  localparam int ADDR_W = 13;
  localparam int DATA_W = 16;
  localparam int LEN_W  = 13;
`ifdef TIMEOUT_EN
  localparam int TO_CYC = 8;
`else
  localparam int TO_CYC = 255;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] src_base = '0;
  logic [ADDR_W-1:0] dst_base = '0;
  logic [LEN_W-1:0]  len = '0;
  logic              busy, done, error;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_w_rn, mem_go;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              mem_done = 1'b0;
  logic              dsec_in_valid;
  logic [DATA_W-1:0] dsec_in_data;
  logic              dsec_out_valid = 1'b0;
  logic [DATA_W-1:0] dsec_out_data = '0;

  always #5 clk = ~clk;

  dsec_mem_sequencer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .src_base(src_base), .dst_base(dst_base), .len(len),
    .busy(busy), .done(done), .error(error),
    .mem_address(mem_address), .mem_w_rn(mem_w_rn), .mem_go(mem_go),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
    .dsec_in_valid(dsec_in_valid), .dsec_in_data(dsec_in_data),
    .dsec_out_valid(dsec_out_valid), .dsec_out_data(dsec_out_data)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] outs_vec();
    return 64'({busy, done, error, mem_go, mem_w_rn, mem_address, mem_wdata,
                dsec_in_valid, dsec_in_data});
  endfunction

  // Scoreboard queues, filled when a transfer is launched.
  logic [ADDR_W-1:0]        rd_q[$];
  logic [DATA_W-1:0]        ds_q[$];
  logic [ADDR_W+DATA_W-1:0] wr_q[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int rd_cnt = 0, wr_cnt = 0, feed_cnt = 0, done_cnt = 0, done_base = 0;
  int first_rd_cyc = -1, done_cyc = -1, feed_cyc = -1, busy_low = 0;
  logic err_at_done = 1'b0;
  bit spurious = 0, dsec_mute = 0;

  logic              mpend = 1'b0, mpend_wr = 1'b0, dpend = 1'b0;
  logic [ADDR_W-1:0] mpend_addr = '0;
  logic [DATA_W-1:0] dpend_data = '0;

  // Memory and DSEC responders (answer one cycle after each strobe) plus the
  // scoreboard monitor; everything here runs mid-cycle, away from posedge.
  always @(negedge clk) begin
    if (!rst) begin
      mpend = 1'b0; dpend = 1'b0;
      mem_done = 1'b0; dsec_out_valid = 1'b0;
    end else begin
      mem_done       = mpend;
      mem_rdata      = (mpend && !mpend_wr) ? (16'hA000 + 16'(mpend_addr)) : 16'h0000;
      dsec_out_valid = dpend && !dsec_mute;
      dsec_out_data  = dpend ? (dpend_data ^ 16'hFFFF) : 16'h0000;
      mpend = mem_go; mpend_addr = mem_address; mpend_wr = mem_w_rn;
      dpend = dsec_in_valid; dpend_data = dsec_in_data;

      if (mem_go && !mem_w_rn) begin
        rd_cnt++;
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
        check("rd_expected", 64'(rd_q.size() != 0), 64'd1);
        if (rd_q.size() != 0) check("rd_addr", 64'(mem_address), 64'(rd_q.pop_front()));
      end
      if (mem_go && mem_w_rn) begin
        wr_cnt++;
        check("wr_expected", 64'(wr_q.size() != 0), 64'd1);
        if (wr_q.size() != 0) check("wr_addr_data", 64'({mem_address, mem_wdata}),
                                    64'(wr_q.pop_front()));
      end
      if (dsec_in_valid) begin
        feed_cnt++;
        feed_cyc = cyc;
        check("ds_expected", 64'(ds_q.size() != 0), 64'd1);
        if (ds_q.size() != 0) check("ds_in_data", 64'(dsec_in_data), 64'(ds_q.pop_front()));
        if (spurious) begin
          mem_done = 1'b1; mem_rdata = 16'hDEAD;
          dsec_out_valid = 1'b1; dsec_out_data = 16'hBEEF;
        end
      end
      if (first_rd_cyc >= 0 && done_cyc < 0 && !busy) busy_low++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        err_at_done = error;
      end
    end
  end

  task automatic start_xfer(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d,
                            input int n, input int n_words_expected);
    logic [ADDR_W-1:0] ra, wa;
    logic [DATA_W-1:0] rv;
    for (int i = 0; i < n_words_expected; i++) begin
      ra = s + ADDR_W'(i);
      wa = d + ADDR_W'(i);
      rv = 16'hA000 + 16'(ra);
      rd_q.push_back(ra);
      ds_q.push_back(rv);
      if (!dsec_mute) wr_q.push_back({wa, rv ^ 16'hFFFF});
    end
    first_rd_cyc = -1; done_cyc = -1; busy_low = 0;
    done_base = done_cnt;
    @(posedge clk); #1;
    start = 1'b1; src_base = s; dst_base = d; len = LEN_W'(n);
    @(posedge clk); #1;
    start = 1'b0; src_base = '0; dst_base = '0; len = '0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    for (int i = 0; i < limit && done_cnt == done_base; i++) begin
      @(negedge clk); #1;
    end
    check({tag, "_done_seen"}, 64'(done_cnt - done_base), 64'd1);
    @(posedge clk); #2;
    check({tag, "_busy_drop"}, 64'({busy, done}), 64'd0);
    check({tag, "_q_empty"}, 64'(rd_q.size() + ds_q.size() + wr_q.size()), 64'd0);
  endtask

  int r0, w0, f0, t0, n0;

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #2;
    check("reset_outputs", outs_vec(), 64'd0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check("idle_outputs", outs_vec(), 64'd0);

    // Three-word transfer: 6 cycles per word, done 18 cycles after first read
    r0 = rd_cnt; w0 = wr_cnt; f0 = feed_cnt;
    start_xfer(13'h0100, 13'h0200, 3, 3);
    wait_done("basic", 100);
    check("basic_latency", 64'(done_cyc - first_rd_cyc), 64'd18);
    check("basic_busy_held", 64'(busy_low), 64'd0);
    check("basic_counts", 64'({16'(rd_cnt - r0), 16'(wr_cnt - w0), 16'(feed_cnt - f0)}),
          {16'd0, 16'd3, 16'd3, 16'd3});

    // Zero-length transfer: no accesses, done on the cycle after acceptance
    r0 = rd_cnt; w0 = wr_cnt; f0 = feed_cnt;
    t0 = cyc;
    start_xfer(13'h0777, 13'h0888, 0, 0);
    wait_done("len0", 20);
    check("len0_done_lat", 64'(done_cyc - t0), 64'd2);
    check("len0_no_access", 64'((rd_cnt - r0) + (wr_cnt - w0) + (feed_cnt - f0)), 64'd0);

    // Source address wraps at the top of the address space
    start_xfer(13'h1FFE, 13'h0010, 3, 3);
    wait_done("wrap", 100);

    // Re-pulsed start while busy and spurious strobes during FEED are ignored
    spurious = 1;
    start_xfer(13'h0300, 13'h0400, 4, 4);
    repeat (5) @(posedge clk);
    #1;
    start = 1'b1; src_base = 13'h0AAA; dst_base = 13'h0BBB; len = 13'd9;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("busy_start", 150);
    check("busy_start_latency", 64'(done_cyc - first_rd_cyc), 64'd24);
    spurious = 0;

`ifdef TIMEOUT_EN
    // DSEC never answers: error with done after TO_CYC DS_WAIT cycles, no write
    dsec_mute = 1;
    w0 = wr_cnt;
    start_xfer(13'h0050, 13'h0060, 2, 1);
    wait_done("timeout", 100);
    check("timeout_error", 64'(err_at_done), 64'd1);
    check("timeout_latency", 64'(done_cyc - feed_cyc), 64'(TO_CYC + 1));
    check("timeout_no_write", 64'(wr_cnt - w0), 64'd0);
    check("timeout_sticky", 64'(error), 64'd1);
    dsec_mute = 0;
    start_xfer(13'h0000, 13'h0000, 0, 0);
    wait_done("err_clear", 20);
    check("err_cleared", 64'(err_at_done), 64'd0);
`endif

    // Reset asserted mid-transfer
    start_xfer(13'h0500, 13'h0600, 3, 3);
    repeat (8) @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_outputs", outs_vec(), 64'd0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    rd_q.delete(); ds_q.delete(); wr_q.delete();
    n0 = rd_cnt + wr_cnt + feed_cnt;
    repeat (20) @(posedge clk);
    #2;
    check("midrst_no_reissue", 64'(rd_cnt + wr_cnt + feed_cnt), 64'(n0));
    check("midrst_idle", outs_vec(), 64'd0);

    // Normal operation after the reset
    start_xfer(13'h0020, 13'h1FFF, 2, 2);
    wait_done("post_rst", 60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dsec_mem_sequencer.md
Name: dsec_mem_sequencer

Overview:
Sequences one block transfer through the DSEC (data stream compression/encryption) core. Each word is read from a source region via the memory controller, presented to DSEC, and the DSEC result is written back to a destination region. The block sits between the top-level control and the memory controller / DSEC pair. It replaces ad-hoc test control with a deterministic one-word-at-a-time engine.

Parameters:
ADDR_W, 13, memory word address width
DATA_W, 16, memory/DSEC data width
LEN_W, 13, transfer length counter width
TIMEOUT_CYC, 255, max cycles waiting on DSEC out_valid (only with TIMEOUT_EN)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
start  in  1  one-cycle pulse: begin transfer; sampled only in IDLE
src_base  in  ADDR_W  source start address; captured on accepted start
dst_base  in  ADDR_W  destination start address; captured on accepted start
len  in  LEN_W  word count; captured on accepted start
busy  out  1  high from the cycle after accepted start until DONE exits
done  out  1  one-cycle pulse at end of transfer
error  out  1  timeout flag; sticky until next accepted start
mem_address  out  ADDR_W  memory address
mem_w_rn  out  1  1 = write, 0 = read
mem_go  out  1  one-cycle access request
mem_wdata  out  DATA_W  write data
mem_rdata  in  DATA_W  read data; valid with mem_done during a read
mem_done  in  1  memory access complete
dsec_in_valid  out  1  one-cycle strobe, word on dsec_in_data
dsec_in_data  out  DATA_W  word to DSEC
dsec_out_valid  in  1  DSEC result strobe
dsec_out_data  in  DATA_W  DSEC result

Behaviour:
- All outputs are registered. Reset values: busy=0, done=0, error=0, mem_go=0, mem_w_rn=0, mem_address=0, mem_wdata=0, dsec_in_valid=0, dsec_in_data=0; state=IDLE; index=0.
- States: IDLE, RD_REQ, RD_WAIT, FEED, DS_WAIT, WR_REQ, WR_WAIT, DONE.
- IDLE: on start, capture the bases and len, set index=0, clear error. If len==0, go to DONE; otherwise go to RD_REQ.
- RD_REQ (1 cycle): mem_go=1, mem_w_rn=0, mem_address=src_base+index. Then go to RD_WAIT.
- RD_WAIT: on mem_done, latch mem_rdata into dsec_in_data and go to FEED.
- FEED (1 cycle): dsec_in_valid=1. Then go to DS_WAIT.
- DS_WAIT: on dsec_out_valid, latch dsec_out_data into mem_wdata and go to WR_REQ.
- WR_REQ (1 cycle): mem_go=1, mem_w_rn=1, mem_address=dst_base+index. Then go to WR_WAIT.
- WR_WAIT: on mem_done, index += 1. If the new index == len, go to DONE; otherwise go to RD_REQ.
- DONE (1 cycle): done=1, busy drops the following cycle, then return to IDLE.
- mem_done and dsec_out_valid are sampled only in their WAIT states, so the earliest response is one cycle after the strobe; strobes in any other state are ignored.
- Minimum of 6 cycles per word (RD_REQ, RD_WAIT, FEED, DS_WAIT, WR_REQ, WR_WAIT).
- Address arithmetic is modulo 2^ADDR_W; base+index wraps silently (0x1FFF+1 -> 0x0000).
- start while busy is ignored; captured parameters are not disturbed.
- mem_w_rn holds its last value when mem_go=0; mem_address holds its last value outside the REQ states.
- Reset asserted mid-transfer: immediate return to IDLE with all outputs at their reset values; no pending access is reissued.

Optional Feature:
TIMEOUT_EN:
- Defined: a counter runs in DS_WAIT. If dsec_out_valid has not arrived after TIMEOUT_CYC cycles, set error=1 and go to DONE, with no write issued for that word. The done pulse still fires. Remaining words are abandoned.
- Undefined: no counter, error is tied 0, and DS_WAIT waits indefinitely.

Test Plan:
- Reset then idle: rst low mid-run -> all outputs 0, state IDLE, no further mem_go.
- src=0x0100, dst=0x0200, len=3; memory returns 0xA000+addr, DSEC echoes data XOR 0xFFFF, responders answer 1 cycle after strobe -> writes to 0x0200..0x0202 with ~(0xA100..0xA102); done exactly 18 cycles after the first RD_REQ cycle; busy high throughout.
- len=0 -> no mem_go and no dsec_in_valid; done pulses 2 cycles after start.
- src=0x1FFE, len=3 -> read addresses 0x1FFE, 0x1FFF, 0x0000.
- start re-pulsed while busy, plus a spurious mem_done/dsec_out_valid in FEED -> ignored; transfer completes unchanged.
- TIMEOUT_EN, TIMEOUT_CYC=8, DSEC never responds -> error=1 and done pulse after 8 DS_WAIT cycles, no write issued; next start clears error.
